// File: rtl/cla_adder.sv
// -----------------------------------------------------------------------------
// cla_adder -- N-bit unsigned carry-lookahead adder with registered outputs.
//
// Computes {C_out, Sum} = A + B with a carry-in of 0. The result is registered,
// so it appears one clock after the operands are presented. A new add can start
// every cycle, and there is no handshake.
//
// Carry structure:
//   - Bit level:   g = A & B and p = A ^ B.
//   - 4-bit group: internal carries are formed in two-level SOP from g/p and
//                  the group carry-in. Each group exports a group generate (G)
//                  and a group propagate (P).
//   - Tree:        4-way lookahead levels combine G/P upward, then carries are
//                  distributed downward. The tree is as deep as N/4 requires,
//                  so N > 16 adds more levels and never ripples.
//
// Parameters:
//   N      operand/sum width; must be a multiple of 4 and >= 4 (default 16)
//
// Ports:
//   clk    in   1  rising-edge clock
//   rst_n  in   1  asynchronous active-low reset; clears Sum/C_out at once
//   A      in   N  unsigned operand A
//   B      in   N  unsigned operand B
//   Sum    out  N  registered low N bits of A+B
//   C_out  out  1  registered carry out of bit N-1
//
// Build option:
//   CLA_INREG_EN  When defined, A and B are first captured in an input register
//                 (reset to 0). The adder then works on the registered values,
//                 which gives a latency of 2 cycles at the same throughput.
//                 When undefined, the adder works on the ports directly and the
//                 latency is 1 cycle.
// -----------------------------------------------------------------------------
module cla_adder #(
    parameter int N = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    output logic [N-1:0] Sum,
    output logic         C_out
);

    // Number of 4-way levels needed to cover n groups.
    function automatic int clog4(input int n);
        int lv;
        int cov;
        lv  = 0;
        cov = 1;
        while (cov < n) begin
            cov = cov * 4;
            lv  = lv + 1;
        end
        return lv;
    endfunction

    // Carries into the four children of a lookahead node, flattened SOP.
    function automatic logic [3:0] la4(input logic [3:0] g, input logic [3:0] p,
                                       input logic ci);
        logic [3:0] c;
        c[0] = ci;
        c[1] = g[0] | (p[0] & ci);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
        return c;
    endfunction

    // Generate/propagate of four children combined, returned as {G, P}.
    function automatic logic [1:0] gp4(input logic [3:0] g, input logic [3:0] p);
        logic gg;
        gg = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
        return {gg, &p};
    endfunction

    localparam int NG  = N / 4;            // 4-bit groups
    localparam int LV  = clog4(NG);        // lookahead levels above the groups
    localparam int NGP = 1 << (2 * LV);    // groups padded to a full 4-ary tree

    logic [N-1:0] op_a, op_b;

`ifdef CLA_INREG_EN
    logic [N-1:0] a_q, b_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q <= '0;
            b_q <= '0;
        end else begin
            a_q <= A;
            b_q <= B;
        end
    end

    assign op_a = a_q;
    assign op_b = b_q;
`else
    assign op_a = A;
    assign op_b = B;
`endif

    logic [N-1:0]            g, p, c;
    logic [LV:0][NGP-1:0]    lg, lp, lc;   // per-level G, P, carry-in
    logic [N-1:0]            sum_d, sum_q;
    logic                    cout_d, cout_q;

    always_comb begin
        g  = op_a & op_b;
        p  = op_a ^ op_b;
        lg = '0;              // padding groups (G=0, P=0) sit above the MSB group
        lp = '0;
        lc = '0;              // the root carry-in is the adder carry-in, which is 0
        c  = '0;

        for (int k = 0; k < NG; k++)
            {lg[0][k], lp[0][k]} = gp4(g[4*k +: 4], p[4*k +: 4]);

        // Upward pass: build each level's G/P from four nodes of the level below.
        for (int l = 1; l <= LV; l++)
            for (int j = 0; j < (NGP >> (2 * l)); j++)
                {lg[l][j], lp[l][j]} = gp4(lg[l-1][4*j +: 4], lp[l-1][4*j +: 4]);

        // Downward pass: each node's carry-in fans out to its four children.
        for (int l = LV; l >= 1; l--)
            for (int j = 0; j < (NGP >> (2 * l)); j++)
                lc[l-1][4*j +: 4] = la4(lg[l-1][4*j +: 4], lp[l-1][4*j +: 4], lc[l][j]);

        for (int k = 0; k < NG; k++)
            c[4*k +: 4] = la4(g[4*k +: 4], p[4*k +: 4], lc[0][k]);

        sum_d  = p ^ c;
        cout_d = lg[0][NG-1] | (lp[0][NG-1] & lc[0][NG-1]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_q  <= '0;
            cout_q <= 1'b0;
        end else begin
            sum_q  <= sum_d;
            cout_q <= cout_d;
        end
    end

    assign Sum   = sum_q;
    assign C_out = cout_q;

endmodule

// File: tb/tb_cla_adder.sv
// -----------------------------------------------------------------------------
// tb_cla_adder -- self-checking bench for cla_adder.
//
// Every cycle the bench drives one operand pair. It pushes the exact A+B
// result, as an N+1 bit value, into a queue. After each rising edge it pops
// and compares the oldest entry once the queue holds LAT entries. Reset
// behaviour is checked directly against zero. Override N (e.g. 32) to
// exercise the deeper lookahead tree.
// -----------------------------------------------------------------------------
module tb_cla_adder;
    localparam int N = 16;
`ifdef CLA_INREG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic         clk;
    logic         rst_n;
    logic [N-1:0] A, B;
    logic [N-1:0] Sum;
    logic         C_out;

    int errors = 0;
    int checks = 0;
    logic [N:0] expq[$];

    cla_adder #(.N(N)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .A     (A),
        .B     (B),
        .Sum   (Sum),
        .C_out (C_out)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [N:0] got, input logic [N:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got C_out=%0b Sum=%0h, want C_out=%0b Sum=%0h",
                     tag, got[N], got[N-1:0], exp[N], exp[N-1:0]);
        end
    endtask

    // Present one operand pair, then wait for the next edge and check the
    // result that is due there.
    task automatic op(input string tag, input logic [N-1:0] a, input logic [N-1:0] b);
        logic [N:0] e;
        A = a;
        B = b;
        expq.push_back({1'b0, a} + {1'b0, b});
        @(posedge clk);
        #1;
        if (expq.size() >= LAT) begin
            e = expq.pop_front();
            chk(tag, {C_out, Sum}, e);
        end
    endtask

    task automatic drain();
        for (int i = 0; i < LAT - 1; i++) op("drain", '0, '0);
    endtask

    logic [N-1:0] ones;
    logic [63:0]  r1, r2;

    initial begin
        ones  = '1;
        rst_n = 1'b0;
        A     = 'x;
        B     = 'x;
        #2;
        chk("reset_async", {C_out, Sum}, '0);
        @(posedge clk);
        #1;
        chk("reset_x_inputs", {C_out, Sum}, '0);
        A = N'(16);
        B = N'(16);
        @(posedge clk);
        #1;
        chk("reset_hold_16_16", {C_out, Sum}, '0);
        rst_n = 1'b1;

        op("first_16_16", N'(16), N'(16));
        drain();

        op("b2b_55_65",   N'(55),  N'(65));
        op("b2b_5_2",     N'(5),   N'(2));
        op("b2b_100_100", N'(100), N'(100));
        drain();

        op("zero",        '0,   '0);
        op("full_carry",  N'(1), ones);
        op("all_ones",    ones, ones);
        op("full_prop",   {(N/2){2'b01}}, {(N/2){2'b10}});
        op("half_rollover", {1'b0, {(N-1){1'b1}}}, N'(1));
        drain();

        // Assert reset between edges, mid-stream.
        op("pre_rst_a", N'(1234), N'(4321));
        op("pre_rst_b", N'(7), N'(9));
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_async", {C_out, Sum}, '0);
        expq.delete();
        @(posedge clk);
        #1;
        chk("midrst_hold", {C_out, Sum}, '0);
        rst_n = 1'b1;
        op("post_rst", N'(3), N'(4));
        drain();

        for (int i = 0; i < 10000; i++) begin
            r1 = {$urandom(), $urandom()};
            r2 = {$urandom(), $urandom()};
            op("rand", r1[N-1:0], r2[N-1:0]);
        end
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
